// File: rtl/sm4_rk_buffer.sv
// SM4 round-key buffer: loads 32 round keys in order, then replays
// them forward (encrypt) or reversed (decrypt) with valid/ready flow.
module sm4_rk_buffer #(
  parameter int WORD_WIDTH = 32,
  parameter int ROUNDS     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  key_clear,
  input  logic                  wr_valid,
  input  logic [WORD_WIDTH-1:0] wr_rk,
  output logic                  wr_ready,
  output logic                  key_ready,
  input  logic                  rd_start,
  input  logic                  rd_decrypt,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [WORD_WIDTH-1:0] rd_rk,
  output logic [4:0]            rd_index,
  output logic                  rd_last
);

  localparam int IW = 5;
  localparam logic [IW-1:0] LAST_IDX = IW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    READ
  } state_t;

  state_t state_q, state_d;

  logic [WORD_WIDTH-1:0] mem [ROUNDS];
  logic [IW-1:0] wr_cnt;
  logic [IW-1:0] start_idx;
  logic [IW-1:0] nxt_idx;
  logic [IW-1:0] end_idx;
  logic          dir_q;
  logic          wr_fire;
  logic          start;
  logic          xfer;
  logic          clr;

  assign wr_ready = (state_q == EMPTY) & !stall;

  // Next state and one-cycle control strobes; stall masks everything.
  always_comb begin
    state_d   = state_q;
    wr_fire   = 1'b0;
    start     = 1'b0;
    xfer      = 1'b0;
    clr       = 1'b0;
    start_idx = rd_decrypt ? LAST_IDX : '0;
    nxt_idx   = dir_q ? rd_index - IW'(1)
                      : rd_index + IW'(1);
    end_idx   = dir_q ? '0 : LAST_IDX;
    if (!stall) begin
      if (key_clear) begin
        clr     = 1'b1;
        state_d = EMPTY;
      end else begin
        unique case (state_q)
          EMPTY: begin
            wr_fire = wr_valid;
            if (wr_valid && wr_cnt == LAST_IDX)
              state_d = FULL;
          end
          FULL: begin
            if (rd_start) begin
              start   = 1'b1;
              state_d = READ;
            end
          end
          READ: begin
            if (rd_valid && rd_ready) begin
              xfer = 1'b1;
              if (rd_last)
                state_d = FULL;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  // Key storage; contents survive reset and are simply rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_cnt] <= wr_rk;
  end

  // Write counter, key_ready and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      key_ready <= 1'b0;
      dir_q     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_rk     <= '0;
      rd_index  <= '0;
      rd_last   <= 1'b0;
    end else if (clr) begin
      wr_cnt    <= '0;
      key_ready <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + IW'(1);
        if (wr_cnt == LAST_IDX)
          key_ready <= 1'b1;
      end
      if (start) begin
        dir_q    <= rd_decrypt;
        rd_index <= start_idx;
        rd_rk    <= mem[start_idx];
        rd_valid <= 1'b1;
        rd_last  <= 1'b0;
      end
      if (xfer) begin
        if (rd_last) begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end else begin
          rd_index <= nxt_idx;
          rd_rk    <= mem[nxt_idx];
          rd_last  <= (nxt_idx == end_idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_sm4_rk_buffer.sv
// Directed bench for sm4_rk_buffer: scoreboard of expected read words,
// popped on every accepted transfer and checked by immediate assertions.
module tb_sm4_rk_buffer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0;
  logic         key_clear = 1'b0;
  logic         wr_valid = 1'b0;
  logic [W-1:0] wr_rk = '0;
  logic         rd_start = 1'b0;
  logic         rd_decrypt = 1'b0;
  logic         rd_ready = 1'b0;
  logic         wr_ready;
  logic         key_ready;
  logic         rd_valid;
  logic [W-1:0] rd_rk;
  logic [4:0]   rd_index;
  logic         rd_last;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc;

  logic [37:0] sb [$];

  sm4_rk_buffer #(.WORD_WIDTH(W), .ROUNDS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .key_clear (key_clear),
    .wr_valid  (wr_valid),
    .wr_rk     (wr_rk),
    .wr_ready  (wr_ready),
    .key_ready (key_ready),
    .rd_start  (rd_start),
    .rd_decrypt(rd_decrypt),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_rk     (rd_rk),
    .rd_index  (rd_index),
    .rd_last   (rd_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Samples at the falling edge, then advances one full clock.
  task automatic cycle();
    logic [37:0]  e;
    logic         hc;
    logic [W-1:0] hrk;
    if (rst_n && rd_valid && rd_ready && !stall && !key_clear) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_word", {26'd0, rd_last, rd_index, rd_rk}, {26'd0, e});
      end
    end
    hc  = rst_n && !key_clear && rd_valid && !(rd_ready && !stall);
    hrk = rd_rk;
    @(posedge clk);
    @(negedge clk);
    if (hc)
      chk("rd_hold", {31'd0, rd_valid, rd_rk}, {31'd0, 1'b1, hrk});
  endtask

  task automatic push_seq(input logic [W-1:0] base, input logic dec);
    logic [4:0] i5;
    for (int k = 0; k < 32; k++) begin
      i5 = dec ? 5'(31 - k) : 5'(k);
      sb.push_back({(k == 31), i5, base + W'(i5)});
    end
  endtask

  task automatic write_keys(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      chk("key_ready_low", {63'd0, key_ready}, 64'd0);
      wr_valid = 1'b1;
      wr_rk    = base + W'(i);
      cycle();
    end
    wr_valid = 1'b0;
  endtask

  task automatic start_read(input logic [W-1:0] base, input logic dec);
    rd_decrypt = dec;
    rd_start   = 1'b1;
    push_seq(base, dec);
    cycle();
    rd_start = 1'b0;
    chk("rd_valid_after_start", {63'd0, rd_valid}, 64'd1);
  endtask

  task automatic run_read(input int max, output int n);
    n = 0;
    while (sb.size() > 0 && n < max) begin
      cycle();
      n++;
    end
    chk("read_left", 64'(sb.size()), 64'd0);
    sb.delete();
    chk("rd_valid_after_seq", {63'd0, rd_valid}, 64'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    stall = 1'b1;
    #2;
    chk("rst_wr_ready_stall", {63'd0, wr_ready}, 64'd0);
    stall = 1'b0;
    #1;
    chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
    chk("rst_key_ready", {63'd0, key_ready}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_rk", {32'd0, rd_rk}, 64'd0);
    chk("rst_rd_index", {59'd0, rd_index}, 64'd0);
    chk("rst_rd_last", {63'd0, rd_last}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    write_keys(32'hA5A50000, 32);
    chk("key_ready_full", {63'd0, key_ready}, 64'd1);
    chk("wr_ready_full", {63'd0, wr_ready}, 64'd0);

    rd_ready = 1'b1;
    start_read(32'hA5A50000, 1'b0);
    run_read(40, cyc);
    chk("enc_no_bubble", 64'(cyc), 64'd32);
    start_read(32'hA5A50000, 1'b1);
    run_read(40, cyc);
    chk("dec_no_bubble", 64'(cyc), 64'd32);
    start_read(32'hA5A50000, 1'b0);
    run_read(40, cyc);
    chk("enc2_no_bubble", 64'(cyc), 64'd32);

    start_read(32'hA5A50000, 1'b0);
    wr_valid = 1'b1;
    wr_rk    = 32'hDEADBEEF;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      rd_ready = 1'($urandom_range(0, 1));
      stall    = ($urandom_range(0, 3) == 0);
      cycle();
      n++;
    end
    stall    = 1'b0;
    rd_ready = 1'b1;
    wr_valid = 1'b0;
    chk("rand_left", 64'(sb.size()), 64'd0);
    sb.delete();
    chk("rand_rd_valid_end", {63'd0, rd_valid}, 64'd0);
    start_read(32'hA5A50000, 1'b1);
    run_read(40, cyc);

    key_clear = 1'b1;
    rd_start  = 1'b1;
    cycle();
    key_clear = 1'b0;
    rd_start  = 1'b0;
    chk("clr_start_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("clr_start_key_ready", {63'd0, key_ready}, 64'd0);
    chk("clr_start_wr_ready", {63'd0, wr_ready}, 64'd1);
    rd_start = 1'b1;
    cycle();
    rd_start = 1'b0;
    chk("empty_start_ignored", {63'd0, rd_valid}, 64'd0);

    for (int i = 0; i < 32; i++) begin
      if (i == 10) begin
        stall    = 1'b1;
        wr_valid = 1'b1;
        wr_rk    = 32'hDEADBEEF;
        cycle();
        cycle();
        chk("stall_wr_ready", {63'd0, wr_ready}, 64'd0);
        stall = 1'b0;
      end
      wr_valid = 1'b1;
      wr_rk    = 32'h5A5A0000 + W'(i);
      cycle();
    end
    wr_valid = 1'b0;
    chk("reload_key_ready", {63'd0, key_ready}, 64'd1);
    start_read(32'h5A5A0000, 1'b0);
    run_read(40, cyc);

    start_read(32'h5A5A0000, 1'b0);
    n = 0;
    while (rd_index != 5'd10 && n < 40) begin
      cycle();
      n++;
    end
    chk("reach_idx10", {59'd0, rd_index}, 64'd10);
    rd_ready  = 1'b0;
    key_clear = 1'b1;
    cycle();
    key_clear = 1'b0;
    rd_ready  = 1'b1;
    sb.delete();
    chk("midclr_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("midclr_key_ready", {63'd0, key_ready}, 64'd0);
    chk("midclr_wr_ready", {63'd0, wr_ready}, 64'd1);

    write_keys(32'h11110000, 17);
    rst_n = 1'b0;
    #1;
    chk("midrst_key_ready", {63'd0, key_ready}, 64'd0);
    chk("midrst_wr_ready", {63'd0, wr_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    write_keys(32'hC3C30000, 32);
    chk("new_key_ready", {63'd0, key_ready}, 64'd1);
    start_read(32'hC3C30000, 1'b0);
    run_read(40, cyc);
    start_read(32'hC3C30000, 1'b1);
    run_read(40, cyc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sm4_rk_buffer.md
SM4_RK_BUFFER -- requirements
Module: sm4_rk_buffer

Interface
REQ-001 Parameter WORD_WIDTH, default 32, round-key word width in bits.
REQ-002 Parameter ROUNDS, default 32, number of round keys stored; index width is 5 bits.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  pipeline stall; freezes all state while high.
REQ-006 key_clear  input  1  discards stored keys and returns the buffer to EMPTY.
REQ-007 wr_valid  input  1  key-expansion side presents a round key.
REQ-008 wr_rk  input  WORD_WIDTH  round key rk[i], delivered in order i=0..31.
REQ-009 wr_ready  output  1  buffer accepts a write this cycle.
REQ-010 key_ready  output  1  all ROUNDS keys stored, buffer readable.
REQ-011 rd_start  input  1  single-cycle request to begin a read sequence.
REQ-012 rd_decrypt  input  1  sampled with rd_start; 1 = reverse order (decrypt), 0 = forward order (encrypt).
REQ-013 rd_ready  input  1  round datapath consumes rd_rk this cycle.
REQ-014 rd_valid  output  1  rd_rk/rd_index valid.
REQ-015 rd_rk  output  WORD_WIDTH  registered round key.
REQ-016 rd_index  output  5  stored index of the key on rd_rk.
REQ-017 rd_last  output  1  high with rd_valid on the 32nd key of a sequence.

Function
REQ-018 The block SHALL implement states EMPTY, FULL and READ.
REQ-019 The block SHALL drive wr_ready = (state==EMPTY) & !stall combinationally; a write is accepted when wr_valid & wr_ready.
REQ-020 In EMPTY, each accepted write SHALL store wr_rk at wr_cnt and increment wr_cnt; the write at wr_cnt=31 SHALL move the state to FULL and set key_ready on the next cycle.
REQ-021 In FULL, rd_start SHALL latch rd_decrypt, load rd_index with 31 (decrypt) or 0 (encrypt), and enter READ, with rd_valid high starting the next cycle.
REQ-022 In READ, rd_rk SHALL equal the stored key at rd_index and SHALL hold stable while rd_valid & !rd_ready.
REQ-023 On each rd_valid & rd_ready & !stall, the block SHALL step rd_index by -1 (decrypt) or +1 (encrypt) and present the new key on the next cycle, with no bubble.
REQ-024 The transfer with rd_last=1 SHALL return the state to FULL with rd_valid low on the next cycle; stored keys SHALL be retained for further sequences.
REQ-025 rd_start SHALL be ignored in EMPTY and READ; wr_valid SHALL be ignored outside EMPTY.
REQ-026 key_clear SHALL override rd_start and any write in the same cycle, from any state, and SHALL go to EMPTY with wr_cnt=0, key_ready=0 and rd_valid=0 on the next cycle; in READ this aborts the sequence.
REQ-027 While stall=1, the block SHALL hold state, counters, memory and all registered outputs, accept no write or read transfer, and ignore rd_start and key_clear.
REQ-028 Priority, highest first: rst_n, stall, key_clear, then normal operation.

Reset
REQ-029 While rst_n=0, the block SHALL hold state=EMPTY, wr_cnt=0, key_ready=0, rd_valid=0, rd_rk=0, rd_index=0, rd_last=0 and the latched direction=0.
REQ-030 Reset SHALL NOT clear key memory contents; contents are don't-care until rewritten.
REQ-031 While rst_n=0, wr_ready SHALL equal !stall.
REQ-032 Reset asserted mid-load or mid-read SHALL abort the operation immediately; after release, 32 fresh writes are required before key_ready.

Verification
REQ-033 Write rk[i]=32'hA5A50000+i for i=0..31 back-to-back, then rd_start with rd_decrypt=0 and rd_ready=1 -> key_ready rises the cycle after the 32nd write; rd_rk = A5A50000..A5A5001F over 32 consecutive cycles; rd_last only at index 31.
REQ-034 Same keys, rd_start with rd_decrypt=1 -> rd_rk sequence A5A5001F down to A5A50000; rd_index 31..0; then the state returns to FULL, and a second encrypt sequence reproduces REQ-033.
REQ-035 Toggle rd_ready randomly and pulse stall during READ -> no key is skipped or duplicated; rd_rk is stable while not accepted; stall during a write leaves wr_cnt unchanged.
REQ-036 key_clear with rd_start in the same FULL cycle, and key_clear at rd_index=10 mid-read -> no read starts in the first case, rd_valid is 0 the next cycle in the second, key_ready=0 and wr_ready=1 in both.
REQ-037 Assert rst_n=0 after 17 writes, release, write 32 new keys -> key_ready=0 until the 32nd new write; a read returns only the new values.
